// File: rtl/inlatch_fifo.sv
// Input data latch that buffers bytes from the pins in a DEPTH-entry FIFO
// and drives DB/ADL/ADH through tri-state enables; a LO/HI sequencer builds a 16-bit address.
module inlatch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     wa,
  input  logic                     rd,
  input  logic                     la,
  input  logic                     oadb,
  input  logic                     oaal,
  input  logic                     oaah,
  output logic [WIDTH-1:0]         databs,
  output logic [WIDTH-1:0]         addrlow,
  output logic [WIDTH-1:0]         addrhi,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     avalid,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wrptr_q, wrptr_d;
  logic [AW-1:0]      rdptr_q, rdptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   addr_lo_q, addr_lo_d;
  logic [WIDTH-1:0]   addr_hi_q, addr_hi_d;
  logic               avalid_q, avalid_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  logic               pop_req, udf_set, load_lo, load_hi, clr_avalid;
  logic               do_push, do_pop, is_full, is_empty;
  logic [WIDTH-1:0]   head;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign head     = mem_q[rdptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_req & ~is_empty;
  assign do_push = wa & (~is_full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (la)        state_d = S_LO;
      S_LO:    if (!is_empty) state_d = S_HI;
      S_HI:    if (!is_empty) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // The sequencer owns the pop path in LO/HI and stalls on empty instead of flagging udf.
  always_comb begin
    pop_req    = 1'b0;
    udf_set    = 1'b0;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    clr_avalid = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop_req    = rd;
        udf_set    = rd & is_empty;
        clr_avalid = la;
      end
      S_LO: begin
        pop_req = 1'b1;
        load_lo = ~is_empty;
      end
      S_HI: begin
        pop_req = 1'b1;
        load_hi = ~is_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    wrptr_d   = do_push ? wrptr_q + AW'(1) : wrptr_q;
    rdptr_d   = do_pop  ? rdptr_q + AW'(1) : rdptr_q;
    count_d   = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    addr_lo_d = load_lo ? head : addr_lo_q;
    addr_hi_d = load_hi ? head : addr_hi_q;
    avalid_d  = avalid_q;
    if (clr_avalid) avalid_d = 1'b0;
    if (load_hi)    avalid_d = 1'b1;
    ovf_d     = ovf_q | (wa & is_full & ~do_pop);
    udf_d     = udf_q | udf_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wrptr_q] <= datain;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrptr_q   <= '0;
      rdptr_q   <= '0;
      count_q   <= '0;
      addr_lo_q <= '0;
      addr_hi_q <= '0;
      avalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wrptr_q   <= wrptr_d;
      rdptr_q   <= rdptr_d;
      count_q   <= count_d;
      addr_lo_q <= addr_lo_d;
      addr_hi_q <= addr_hi_d;
      avalid_q  <= avalid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign databs  = oadb ? head      : {WIDTH{1'bz}};
  assign addrlow = oaal ? addr_lo_q : {WIDTH{1'bz}};
  assign addrhi  = oaah ? addr_hi_q : {WIDTH{1'bz}};
  assign count   = count_q;
  assign full    = is_full;
  assign empty   = is_empty;
  assign avalid  = avalid_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule

// File: doc/inlatch_fifo.md
# inlatch_fifo

Parametrised input data latch for the 6502 datapath: buffers bytes arriving from the external data pins in a DEPTH-entry FIFO instead of a single latch. It drives the internal data bus and the low/high address buses through tri-state enables. A built-in two-step sequencer assembles a 16-bit operand address (low byte, then high byte) from consecutive entries. It sits between the pin interface and the internal data bus (DB), the address-low bus (ADL) and the address-high bus (ADH).

## Interface
- WIDTH, 8, data width of every entry, bus and address register
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  asynchronous active-low reset
- datain  in  WIDTH  byte from the external data pins
- wa  in  1  write/push strobe; samples datain
- rd  in  1  pop the head entry (DB consumer done)
- la  in  1  start the address-assembly sequence
- oadb  in  1  drive the head entry onto databs
- oaal  in  1  drive the address-low register onto addrlow
- oaah  in  1  drive the address-high register onto addrhi
- databs  out  WIDTH  internal data bus; high-Z when oadb=0
- addrlow  out  WIDTH  ADL bus; high-Z when oaal=0
- addrhi  out  WIDTH  ADH bus; high-Z when oaah=0
- count  out  $clog2(DEPTH)+1  number of occupied entries
- full, empty  out  1  combinational from count
- avalid  out  1  an assembled address is held in the address registers
- ovf, udf  out  1  sticky overflow / underflow flags

## Operation
- Reset (rstn low, asynchronous): storage, read/write pointers, count, address registers, ovf, udf and avalid all go to 0; the sequencer goes to IDLE. Outputs stay governed by the enables: with oadb=1 during reset, databs drives 0.
- Push: wa=1 and not full writes datain at the write pointer, and the write pointer increments mod DEPTH.
  - wa=1 while full: the write is dropped and ovf is set.
  - Exception: a push while full is accepted when a pop occurs in the same cycle.
- Pop: the pop source is rd in IDLE, or the sequencer in LO/HI.
  - A pop while not empty advances the read pointer mod DEPTH.
  - A pop while empty is ignored and sets udf. The exception is the sequencer, which waits instead (see below).
- Count update: push and pop in the same cycle leave count unchanged. A simultaneous push and pop while empty counts as a push only.
- databs always shows storage[rdptr] when oadb=1, whether or not the FIFO is empty.
- Sequencer states:
  - IDLE: la=1 goes to LO and clears avalid. rd is honoured.
  - LO: rd is ignored. If not empty, pop the head into addr_lo and go to HI; if empty, stay in LO.
  - HI: rd is ignored. If not empty, pop the head into addr_hi, set avalid, and go to IDLE; if empty, stay in HI.
  - la while in LO or HI is ignored.
- addrlow shows addr_lo when oaal=1; addrhi shows addr_hi when oaah=1.
- ovf and udf clear only on reset.

## Timing
- Push latency: a byte pushed at edge N is on databs (if it is the head) after edge N.
- Address latency: la sampled at edge N gives LO at N, addr_lo loaded at N+1, addr_hi loaded and avalid=1 at N+2. The minimum is 2 cycles when there are 2 or more entries; each empty cycle adds one stall cycle.
- Bus enables are combinational: a bus leaves high-Z in the same cycle its enable rises.
- Pointer wrap-around: after DEPTH pushes the write pointer returns to 0; pointer comparison uses count, not pointer equality.
- Asynchronous reset in the middle of a sequence (LO/HI) aborts it: avalid=0, and the partially loaded addr_lo returns to 0.

## Test plan
- Reset, then oadb=1 → databs=00, count=0, empty=1. With all enables at 0 → all three buses Z.
- Push 52, 92 (wa for 2 cycles), oadb=1 → databs=52. rd for 1 cycle → databs=92, count=1.
- Push 4 bytes into DEPTH=4 → full=1. A fifth push (AA) → ovf=1 and the value is not stored. Push plus rd in the same full cycle → count stays 4 and the new byte lands at the wrapped slot.
- Push 34, 12; pulse la → after 2 edges avalid=1. oaal=1 → addrlow=34; oaah=1 → addrhi=12. count=0.
- With 1 entry (34), pulse la → stays in HI after the low byte. Push 12 three cycles later → avalid rises on the edge after that push.
- rd while empty → udf=1 and count stays 0. rstn low mid-sequence → avalid=0, addrlow=00 under oaal=1.
